// File: rtl/hazard_controller.sv
// Pipeline hazard controller: decides per cycle which 5-stage pipeline registers hold or take a bubble,
// tracks outstanding data-cache misses with a watchdog, and keeps saturating stall/flush counters.
module hazard_controller #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_rs1_ID,
  input  logic [4:0]       i_rs2_ID,
  input  logic [4:0]       i_write_reg_EX,
  input  logic             i_memread_EX,
  input  logic             i_branch_taken_EX,
  input  logic             i_dmem_req_MEM,
  input  logic             i_dmem_ready,
  input  logic             i_imem_ready,
  output logic             o_pc_write,
  output logic             o_stall_IF_ID,
  output logic             o_stall_ID_EX,
  output logic             o_stall_EX_MEM,
  output logic             o_flush_IF_ID,
  output logic             o_flush_ID_EX,
  output logic             o_flush_MEM_WB,
  output logic             o_busy,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic        freeze;
  logic        load_use;
  logic        br_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign load_use = i_memread_EX && (i_write_reg_EX != 5'd0) &&
                    ((i_write_reg_EX == i_rs1_ID) || (i_write_reg_EX == i_rs2_ID));

  assign o_busy = (state != RUN);

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    freeze    = 1'b0;
    case (state)
      RUN: begin
        if (i_dmem_req_MEM && !i_dmem_ready) begin
          freeze    = 1'b1;
          state_nxt = DWAIT;
          wait_nxt  = '0;
        end
      end
      DWAIT: begin
        if (!i_dmem_ready) begin
          freeze = 1'b1;
          if (wait_cnt == WAIT_LAST) state_nxt = ERR;
          else                       wait_nxt  = wait_cnt + 16'd1;
        end else begin
          // Release cycle: MEM/WB captures the data, rest of pipeline follows normal rules
          state_nxt = RUN;
          wait_nxt  = '0;
        end
      end
      ERR:     freeze = 1'b1;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    o_pc_write     = 1'b1;
    o_stall_IF_ID  = 1'b0;
    o_stall_ID_EX  = 1'b0;
    o_stall_EX_MEM = 1'b0;
    o_flush_IF_ID  = 1'b0;
    o_flush_ID_EX  = 1'b0;
    o_flush_MEM_WB = 1'b0;
    br_flush       = 1'b0;
    if (i_rst) begin
      o_pc_write     = 1'b0;
      o_flush_IF_ID  = 1'b1;
      o_flush_ID_EX  = 1'b1;
      o_flush_MEM_WB = 1'b1;
    end else if (freeze) begin
      o_pc_write     = 1'b0;
      o_stall_IF_ID  = 1'b1;
      o_stall_ID_EX  = 1'b1;
      o_stall_EX_MEM = 1'b1;
      o_flush_MEM_WB = 1'b1;
    end else if (i_branch_taken_EX) begin
      // A taken branch squashes the younger instructions, so any load-use stall is moot
      o_flush_IF_ID = 1'b1;
      o_flush_ID_EX = 1'b1;
      br_flush      = 1'b1;
    end else if (load_use) begin
      o_pc_write    = 1'b0;
      o_stall_IF_ID = 1'b1;
      o_flush_ID_EX = 1'b1;
    end else if (!i_imem_ready) begin
      o_pc_write    = 1'b0;
      o_flush_IF_ID = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= RUN;
      wait_cnt       <= '0;
      o_timeout      <= 1'b0;
      o_stall_cycles <= '0;
      o_flush_count  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state_nxt == ERR) o_timeout <= 1'b1;
      if (!o_pc_write) o_stall_cycles <= sat_inc(o_stall_cycles);
      if (br_flush)    o_flush_count  <= sat_inc(o_flush_count);
    end
  end

endmodule
